// File: rtl/sdram_responder_model.sv
// sdram_responder_model: on-chip memory responder for the rd/wr/refresh/busy/data_ready interface
// clk/resetn: single clock, synchronous active-low reset
// addr/din: word address and write data, captured on acceptance
// rd/wr/refresh: request levels, priority refresh > wr > rd
// dout/data_ready: read data, valid for one cycle when a read completes
// busy: command in progress, high for exactly the command latency
// refresh_err/proto_err: sticky refresh-interval and initiator-protocol flags
module sdram_responder_model #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 10,
  parameter int RD_LAT  = 4,
  parameter int WR_LAT  = 3,
  parameter int REF_LAT = 8,
  parameter int REF_MAX = 810
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  input  logic              wr,
  input  logic              refresh,
  output logic [DATA_W-1:0] dout,
  output logic              data_ready,
  output logic              busy,
  output logic              refresh_err,
  output logic              proto_err
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, REFR} state_t;
  state_t state;
  logic [15:0] cnt, iv;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic [2:0] req_acc;
  logic [DATA_W-1:0] mem [0:(1<<DEPTH_W)-1];
  logic [2:0] req;
  logic accept, done, held, viol, ref_acc;
  always_comb begin
    req = {refresh, wr, rd};
    accept = state == IDLE && |req;
    ref_acc = accept && refresh;
    done = state != IDLE && cnt == 16'd0;
    held = state == READ ? rd : state == WRITE ? wr : refresh;
    // new requests while busy, or operands moving under a still-held request
    viol = state != IDLE && (|(req & ~req_acc) || (held && (addr != a || din != d)));
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      data_ready <= 1'b0;
      dout <= '0;
      refresh_err <= 1'b0;
      proto_err <= 1'b0;
      cnt <= '0;
      iv <= '0;
      a <= '0;
      d <= '0;
      req_acc <= '0;
    end else begin
      data_ready <= done && state == READ;
      if (done && state == READ) dout <= mem[a[DEPTH_W-1:0]];
      proto_err <= proto_err | viol;
      iv <= ref_acc ? 16'd0 : (&iv ? iv : iv + 16'd1);
      refresh_err <= refresh_err | (!ref_acc && iv >= 16'(REF_MAX));
      if (accept) begin
        a <= addr;
        d <= din;
        req_acc <= req;
        busy <= 1'b1;
        state <= refresh ? REFR : wr ? WRITE : READ;
        cnt <= refresh ? 16'(REF_LAT - 1) : wr ? 16'(WR_LAT - 1) : 16'(RD_LAT - 1);
      end else if (done) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= cnt - 16'd1;
      end
    end
  end
  always_ff @(posedge clk)
    if (resetn && done && state == WRITE) mem[a[DEPTH_W-1:0]] <= d;
endmodule

// File: tb/tb_sdram_responder_model.sv
// tb_sdram_responder_model: directed vector bench for sdram_responder_model
module tb_sdram_responder_model;
  logic clk = 1'b0, resetn = 1'b0, rd = 1'b0, wr = 1'b0, refresh = 1'b0;
  logic [22:0] addr = '0;
  logic [31:0] din = '0, dout;
  logic data_ready, busy, refresh_err, proto_err;
  int nvec = 0, nerr = 0;

  sdram_responder_model dut (
    .clk(clk), .resetn(resetn), .addr(addr), .din(din), .rd(rd), .wr(wr),
    .refresh(refresh), .dout(dout), .data_ready(data_ready), .busy(busy),
    .refresh_err(refresh_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, w, f;
    logic [22:0] a;
    logic [31:0] d;
    int blen, drc;
    logic [31:0] dout;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic cmd(input logic r, input logic w, input logic f, input logic [22:0] a,
                     input logic [31:0] d, output int blen, output int drc, output logic [31:0] dd);
    @(negedge clk); rd = r; wr = w; refresh = f; addr = a; din = d;
    @(negedge clk); rd = 1'b0; wr = 1'b0; refresh = 1'b0;
    blen = 0; drc = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_ready) drc++;
      if (!busy) break;
      blen++;
      @(negedge clk);
    end
    dd = dout;
  endtask

  initial begin
    int blen, drc;
    logic [31:0] dd;
    logic [11:0] bp, dp;
    tv[0]  = '{1'b0, 1'b1, 1'b0, 23'h5,   32'hA5A5_1234, 3, 0, 32'h0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 23'h5,   32'h0,         4, 1, 32'hA5A5_1234};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 23'h5,   32'hFFFF_FFFF, 8, 0, 32'hA5A5_1234};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 23'h5,   32'h0,         4, 1, 32'hA5A5_1234};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 23'h400, 32'h1,         3, 0, 32'hA5A5_1234};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 23'h0,   32'h0,         4, 1, 32'h1};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 23'h7,   32'hCAFE_F00D, 3, 0, 32'h1};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 23'h7,   32'h0,         3, 0, 32'h1};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 23'h7,   32'h0,         4, 1, 32'h0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 23'h5,   32'h0,         4, 1, 32'hA5A5_1234};
    tv[10] = '{1'b0, 1'b0, 1'b1, 23'h3,   32'h0,         8, 0, 32'hA5A5_1234};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dr", 32'(data_ready), 32'h0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_referr", 32'(refresh_err), 32'h0);
    chk("rst_proterr", 32'(proto_err), 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cmd(tv[i].r, tv[i].w, tv[i].f, tv[i].a, tv[i].d, blen, drc, dd);
      chk($sformatf("v%0d_busylen", i), 32'(blen), 32'(tv[i].blen));
      chk($sformatf("v%0d_drcount", i), 32'(drc), 32'(tv[i].drc));
      chk($sformatf("v%0d_dout", i), dd, tv[i].dout);
    end
    chk("table_proterr", 32'(proto_err), 32'h0);

    @(negedge clk); rd = 1'b1; addr = 23'h5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bp[i] = busy;
      dp[i] = data_ready;
      if (i == 5) rd = 1'b0;
    end
    chk("hold_busy_pattern", 32'(bp), 32'h1EF);
    chk("hold_dr_pattern", 32'(dp), 32'h210);
    chk("hold_proterr", 32'(proto_err), 32'h0);

    @(negedge clk); wr = 1'b1; addr = 23'h5; din = 32'hBADB_AD00;
    @(negedge clk); wr = 1'b0;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_dr", 32'(data_ready), 32'h0);
    chk("abort_dout", dout, 32'h0);
    @(negedge clk);
    chk("abort_busy2", 32'(busy), 32'h0);
    cmd(1'b1, 1'b0, 1'b0, 23'h5, 32'h0, blen, drc, dd);
    chk("abort_rd_len", 32'(blen), 32'h4);
    chk("abort_rd_dout", dd, 32'hA5A5_1234);

    @(negedge clk); rd = 1'b1; addr = 23'h5;
    @(negedge clk); rd = 1'b0;
    @(negedge clk); wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    chk("proto_extra_req", 32'(proto_err), 32'h1);
    repeat (10) @(negedge clk);
    chk("proto_sticky", 32'(proto_err), 32'h1);
    do_reset();
    chk("proto_cleared", 32'(proto_err), 32'h0);

    @(negedge clk); rd = 1'b1; addr = 23'h5;
    @(negedge clk);
    chk("proto_addr_ok", 32'(proto_err), 32'h0);
    addr = 23'h6;
    @(negedge clk); rd = 1'b0;
    chk("proto_addr_change", 32'(proto_err), 32'h1);
    repeat (6) @(negedge clk);

    do_reset();
    repeat (810) @(negedge clk);
    chk("referr_at_810", 32'(refresh_err), 32'h0);
    @(negedge clk);
    chk("referr_at_811", 32'(refresh_err), 32'h1);
    repeat (5) @(negedge clk);
    chk("referr_sticky", 32'(refresh_err), 32'h1);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      repeat (799) @(negedge clk);
      refresh = 1'b1;
      @(negedge clk); refresh = 1'b0;
      chk($sformatf("ref%0d_busy", k), 32'(busy), 32'h1);
    end
    repeat (805) @(negedge clk);
    chk("referr_periodic", 32'(refresh_err), 32'h0);
    chk("periodic_proterr", 32'(proto_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
